// File: rtl/wb_alu_pkg.sv
// ============================================================================
// Module : wb_alu_pkg
// Brief  : Shared opcode, FSM state and width definitions for the write-back ALU.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package wb_alu_pkg;

  localparam int unsigned c_DATA_W  = 8;
  localparam int unsigned c_SHAMT_W = 3;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_XOR  = 3'd4,
    OP_SHL  = 3'd5,
    OP_SHR  = 3'd6,
    OP_PASS = 3'd7
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_WB    = 2'd2
  } state_t;

  function automatic logic is_shift(input alu_op_t op);
    return (op == OP_SHL) || (op == OP_SHR);
  endfunction

endpackage

`default_nettype wire

// File: rtl/wb_alu_comb.sv
// ============================================================================
// Module : alu_comb
// Brief  : Single-cycle ADD/SUB/logic/PASS evaluation; shifts pass op_a through.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_comb
  import wb_alu_pkg::*;
(
  input  alu_op_t                op,
  input  logic [c_DATA_W-1:0]    a,
  input  logic [c_DATA_W-1:0]    b,
  output logic [c_DATA_W-1:0]    result,
  output logic                   carry
);

  always_comb begin
    result = '0;
    carry  = 1'b0;
    case (op)
      OP_ADD:  {carry, result} = {1'b0, a} + {1'b0, b};
      OP_SUB: begin
        result = a - b;
        carry  = (a < b);
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_PASS: result = b;
      // Only zero-amount shifts reach this path; they leave op_a untouched.
      default: result = a;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/wb_alu.sv
// ============================================================================
// Module : wb_alu
// Brief  : Register-file write-back ALU with bit-serial shifter and flush.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module wb_alu
  import wb_alu_pkg::*;
#(
  parameter int PW = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2:0]          op,
  input  logic [7:0]          op_a,
  input  logic [7:0]          op_b,
  input  logic [PW:0]         dst,
  input  logic                flush,
  output logic                wr_en,
  output logic [PW:0]         wr_addr,
  output logic [7:0]          dat_out,
  output logic                zero,
  output logic                ngtv,
  output logic                scry
);

  state_t                 r_state;
  alu_op_t                r_op;
  logic [c_DATA_W-1:0]    r_acc;
  logic [c_SHAMT_W-1:0]   r_cnt;
  logic [PW:0]            r_dst;

  alu_op_t                w_op;
  logic [c_SHAMT_W-1:0]   w_shamt;
  logic                   w_accept;
  logic [c_DATA_W-1:0]    w_alu_res;
  logic                   w_alu_cry;
  logic [c_DATA_W-1:0]    w_shift_val;
  logic                   w_shift_bit;

  assign w_op     = alu_op_t'(op);
  assign w_shamt  = op_b[c_SHAMT_W-1:0];
  assign in_ready = (r_state == ST_IDLE);
  assign w_accept = in_valid & in_ready & ~flush;

  alu_comb u_alu_comb (
    .op     (w_op),
    .a      (op_a),
    .b      (op_b),
    .result (w_alu_res),
    .carry  (w_alu_cry)
  );

  // One bit per cycle; the bit leaving the word becomes the carry flag.
  assign w_shift_val = (r_op == OP_SHL) ? {r_acc[6:0], 1'b0} : {1'b0, r_acc[7:1]};
  assign w_shift_bit = (r_op == OP_SHL) ? r_acc[7] : r_acc[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_op    <= OP_ADD;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_dst   <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      dat_out <= '0;
      zero    <= 1'b0;
      ngtv    <= 1'b0;
      scry    <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (is_shift(w_op) && (w_shamt != '0)) begin
              r_state <= ST_SHIFT;
              r_op    <= w_op;
              r_acc   <= op_a;
              r_cnt   <= w_shamt;
              r_dst   <= dst;
            end else begin
              r_state <= ST_WB;
              wr_en   <= 1'b1;
              wr_addr <= dst;
              dat_out <= w_alu_res;
              zero    <= (w_alu_res == '0);
              ngtv    <= w_alu_res[7];
              scry    <= w_alu_cry;
            end
          end
        end
        ST_SHIFT: begin
          if (flush) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end else begin
            r_acc <= w_shift_val;
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == 3'd1) begin
              r_state <= ST_WB;
              wr_en   <= 1'b1;
              wr_addr <= r_dst;
              dat_out <= w_shift_val;
              zero    <= (w_shift_val == '0);
              ngtv    <= w_shift_val[7];
              scry    <= w_shift_bit;
            end
          end
        end
        ST_WB:   r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_wb_alu.sv
// ============================================================================
// Module : tb_wb_alu
// Brief  : Directed vector table plus flush / async-reset / streaming sequences.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_wb_alu;

  localparam int PW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    op;
  logic [7:0]    op_a;
  logic [7:0]    op_b;
  logic [PW:0]   dst;
  logic          flush;
  logic          wr_en;
  logic [PW:0]   wr_addr;
  logic [7:0]    dat_out;
  logic          zero;
  logic          ngtv;
  logic          scry;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  wb_alu #(.PW(PW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .op_a     (op_a),
    .op_b     (op_b),
    .dst      (dst),
    .flush    (flush),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .dat_out  (dat_out),
    .zero     (zero),
    .ngtv     (ngtv),
    .scry     (scry)
  );

  typedef struct {
    logic [2:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [3:0]  dst;
    logic [7:0]  res;
    logic [2:0]  znc;
    int          lat;
  } vec_t;

  vec_t vecs[13];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_ready();
    int t = 0;
    while (!in_ready && t < 20) begin
      step();
      t++;
    end
    chk("ready_wait", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic run_op(input string name, input vec_t v);
    int lat;
    int ready_seen;
    wait_ready();
    op = v.op; op_a = v.a; op_b = v.b; dst = v.dst; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    lat = 1;
    ready_seen = 0;
    while (!wr_en && lat < 20) begin
      if (in_ready) ready_seen++;
      step();
      lat++;
    end
    chk($sformatf("%s latency", name), lat, v.lat);
    chk($sformatf("%s wr_en", name), {31'd0, wr_en}, 32'd1);
    chk($sformatf("%s busy in_ready", name), ready_seen + {31'd0, in_ready}, 0);
    chk($sformatf("%s wr_addr", name), {28'd0, wr_addr}, {28'd0, v.dst});
    chk($sformatf("%s dat_out", name), {24'd0, dat_out}, {24'd0, v.res});
    chk($sformatf("%s flags znc", name), {29'd0, zero, ngtv, scry}, {29'd0, v.znc});
    step();
    chk($sformatf("%s single strobe", name), {31'd0, wr_en}, 32'd0);
  endtask

  initial begin
    int cnt;
    int n_acc;
    int n_wr;
    logic [11:0] q[$];
    logic [11:0] exp_w;

    //           op     a      b      dst    res    znc     lat
    vecs[0]  = '{3'd0, 8'hF0, 8'h20, 4'd3,  8'h10, 3'b001, 1};
    vecs[1]  = '{3'd1, 8'h05, 8'h05, 4'd1,  8'h00, 3'b100, 1};
    vecs[2]  = '{3'd1, 8'h03, 8'h05, 4'd2,  8'hFE, 3'b011, 1};
    vecs[3]  = '{3'd2, 8'hF0, 8'h3C, 4'd4,  8'h30, 3'b000, 1};
    vecs[4]  = '{3'd3, 8'h0F, 8'h80, 4'd5,  8'h8F, 3'b010, 1};
    vecs[5]  = '{3'd4, 8'hAA, 8'hAA, 4'd6,  8'h00, 3'b100, 1};
    vecs[6]  = '{3'd7, 8'h11, 8'hC3, 4'd7,  8'hC3, 3'b010, 1};
    vecs[7]  = '{3'd5, 8'h81, 8'h03, 4'd8,  8'h08, 3'b000, 4};
    vecs[8]  = '{3'd6, 8'h81, 8'h01, 4'd9,  8'h40, 3'b001, 2};
    vecs[9]  = '{3'd5, 8'h80, 8'hF8, 4'd10, 8'h80, 3'b010, 1};
    vecs[10] = '{3'd6, 8'hFF, 8'h07, 4'd11, 8'h01, 3'b001, 8};
    vecs[11] = '{3'd5, 8'h01, 8'h0F, 4'd12, 8'h80, 3'b010, 8};
    vecs[12] = '{3'd0, 8'hFF, 8'h01, 4'd15, 8'h00, 3'b101, 1};

    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0;
    op = '0; op_a = '0; op_b = '0; dst = '0;
    #12;
    chk("reset wr_en", {31'd0, wr_en}, 32'd0);
    chk("reset outputs", {19'd0, wr_addr, dat_out, zero, ngtv, scry}, 32'd0);
    chk("reset in_ready", {31'd0, in_ready}, 32'd1);
    step();
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) run_op($sformatf("vec%0d", i), vecs[i]);

    // Flush during the third SHIFT cycle of a 7-bit shift
    wait_ready();
    op = 3'd6; op_a = 8'hFF; op_b = 8'h07; dst = 4'd14; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush in_ready", {31'd0, in_ready}, 32'd1);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (wr_en) cnt++;
      step();
    end
    chk("flush no write", cnt, 0);
    run_op("after flush", '{3'd0, 8'h12, 8'h34, 4'd2, 8'h46, 3'b000, 1});

    // Flush while idle blocks the request
    in_valid = 1'b1; flush = 1'b1; op = 3'd7; op_b = 8'h55; dst = 4'd9;
    step();
    in_valid = 1'b0; flush = 1'b0;
    chk("idle flush not accepted", {31'd0, in_ready}, 32'd1);
    step();
    chk("idle flush no write", {31'd0, wr_en}, 32'd0);

    // Asynchronous reset in the middle of a shift
    run_op("pre-reset pass", '{3'd7, 8'h00, 8'hFF, 4'd7, 8'hFF, 3'b010, 1});
    chk("pre-reset dat_out hold", {24'd0, dat_out}, 32'hFF);
    wait_ready();
    op = 3'd5; op_a = 8'h81; op_b = 8'h03; dst = 4'd5; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("async rst wr_en", {31'd0, wr_en}, 32'd0);
    chk("async rst outputs", {19'd0, wr_addr, dat_out, zero, ngtv, scry}, 32'd0);
    chk("async rst in_ready", {31'd0, in_ready}, 32'd1);
    step();
    rst_n = 1'b1;
    run_op("first after reset", '{3'd7, 8'h00, 8'h3C, 4'd4, 8'h3C, 3'b000, 1});
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (wr_en) cnt++;
      step();
    end
    chk("no stale write", cnt, 0);

    // Streaming PASS ops with in_valid held high
    n_acc = 0; n_wr = 0;
    op = 3'd7; in_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (wr_en) begin
        n_wr++;
        if (q.size() == 0) chk("stream spurious wr_en", {31'd0, wr_en}, 32'd0);
        else begin
          exp_w = q.pop_front();
          chk($sformatf("stream write %0d", n_wr), {20'd0, wr_addr, dat_out}, {20'd0, exp_w});
        end
      end
      if (in_ready) begin
        op_b = 8'hA0 + 8'(i);
        dst = 4'(i + 1);
        q.push_back({4'(i + 1), 8'hA0 + 8'(i)});
        n_acc++;
      end
      step();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (wr_en) begin
        n_wr++;
        if (q.size() != 0) void'(q.pop_front());
      end
      step();
    end
    chk("stream accepts", n_acc, 6);
    chk("stream writes", n_wr, 6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
